// File: rtl/mbus_mem_responder.sv
// rtl/mbus_mem_responder.sv - mbus responder serving AR/R and AW+W/B from an on-chip SRAM window
// One outstanding transaction per channel pair; read data is registered after a programmable latency.
module mbus_mem_responder #(
   parameter int                         MBUS_ADDR_WIDTH = 32,
   parameter int                         MBUS_DATA_WIDTH = 32,
   parameter int                         MEM_ADDR_BITS   = 10,
   parameter logic [MBUS_ADDR_WIDTH-1:0] MEM_BASE        = '0,
   parameter int                         READ_LATENCY    = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [MBUS_ADDR_WIDTH-1:0]     mbus_ar_addr,
   input  logic                           mbus_ar_valid,
   output logic                           mbus_ar_ready,
   output logic [MBUS_DATA_WIDTH-1:0]     mbus_r_data,
   output logic                           mbus_r_valid,
   input  logic                           mbus_r_ready,
   input  logic [MBUS_ADDR_WIDTH-1:0]     mbus_aw_addr,
   input  logic                           mbus_aw_valid,
   output logic                           mbus_aw_ready,
   input  logic [MBUS_DATA_WIDTH-1:0]     mbus_w_data,
   input  logic                           mbus_w_valid,
   input  logic [MBUS_DATA_WIDTH/8-1:0]   mbus_w_strb,
   output logic                           mbus_b_resp,
   output logic                           mbus_b_valid,
   input  logic                           mbus_b_ready
);

   localparam int AW    = MBUS_ADDR_WIDTH;
   localparam int DW    = MBUS_DATA_WIDTH;
   localparam int DW_B  = MBUS_DATA_WIDTH / 8;
   localparam int DEPTH = 1 << MEM_ADDR_BITS;
   localparam logic [AW:0] MEM_WIN =
      {{(AW-MEM_ADDR_BITS-2){1'b0}}, 1'b1, {(MEM_ADDR_BITS+2){1'b0}}};
   localparam logic [3:0] LAT = 4'(READ_LATENCY);

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
   typedef enum logic       {W_IDLE, W_RESP}         w_state_t;

   r_state_t r_state, r_next;
   w_state_t w_state, w_next;

   logic [DW-1:0] mem [DEPTH];

   logic [AW:0]              ar_off, aw_off;
   logic                     ar_in, aw_in;
   logic [MEM_ADDR_BITS-1:0] ar_idx, aw_idx;
   logic [MEM_ADDR_BITS-1:0] rd_idx_q, rd_idx;
   logic                     rd_ok_q, rd_ok;
   logic [3:0]               cnt;
   logic                     ar_take, rd_fire, aw_take, wr_en;
   logic [DW-1:0]            rd_word;

   // One extra bit makes addresses below MEM_BASE wrap high, so a single compare covers both bounds.
   assign ar_off = {1'b0, mbus_ar_addr} - {1'b0, MEM_BASE};
   assign aw_off = {1'b0, mbus_aw_addr} - {1'b0, MEM_BASE};
   assign ar_in  = ar_off < MEM_WIN;
   assign aw_in  = aw_off < MEM_WIN;
   assign ar_idx = ar_off[MEM_ADDR_BITS+1:2];
   assign aw_idx = aw_off[MEM_ADDR_BITS+1:2];

   assign wr_en  = aw_take & aw_in & rst_n;
   assign rd_idx = (r_state == R_IDLE) ? ar_idx : rd_idx_q;
   assign rd_ok  = (r_state == R_IDLE) ? ar_in  : rd_ok_q;

   always_comb begin
      r_next        = r_state;
      mbus_ar_ready = 1'b0;
      mbus_r_valid  = 1'b0;
      ar_take       = 1'b0;
      rd_fire       = 1'b0;
      case (r_state)
         R_IDLE: begin
            mbus_ar_ready = 1'b1;
            if (mbus_ar_valid) begin
               ar_take = 1'b1;
               if (LAT == 4'd0) begin
                  rd_fire = 1'b1;
                  r_next  = R_RESP;
               end else begin
                  r_next  = R_WAIT;
               end
            end
         end
         R_WAIT: begin
            if (cnt == 4'd1) begin
               rd_fire = 1'b1;
               r_next  = R_RESP;
            end
         end
         R_RESP: begin
            mbus_r_valid = 1'b1;
            if (mbus_r_ready) r_next = R_IDLE;
         end
         default: r_next = R_IDLE;
      endcase
   end

   always_comb begin
      w_next        = w_state;
      mbus_aw_ready = 1'b0;
      mbus_b_valid  = 1'b0;
      aw_take       = 1'b0;
      case (w_state)
         W_IDLE: begin
            mbus_aw_ready = 1'b1;
            if (mbus_aw_valid && mbus_w_valid) begin
               aw_take = 1'b1;
               w_next  = W_RESP;
            end
         end
         W_RESP: begin
            mbus_b_valid = 1'b1;
            if (mbus_b_ready) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   // Write-first: a write landing in the capture cycle is merged lane by lane.
   always_comb begin
      rd_word = mem[rd_idx];
      for (int i = 0; i < DW_B; i++) begin
         if (wr_en && (aw_idx == rd_idx) && mbus_w_strb[i])
            rd_word[8*i +: 8] = mbus_w_data[8*i +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= R_IDLE;
         w_state     <= W_IDLE;
         cnt         <= 4'd0;
         rd_idx_q    <= '0;
         rd_ok_q     <= 1'b0;
         mbus_r_data <= '0;
         mbus_b_resp <= 1'b0;
      end else begin
         r_state <= r_next;
         w_state <= w_next;
         if (ar_take) begin
            cnt      <= LAT;
            rd_idx_q <= ar_idx;
            rd_ok_q  <= ar_in;
         end else if (r_state == R_WAIT) begin
            cnt <= cnt - 4'd1;
         end
         if (rd_fire) mbus_r_data <= rd_ok ? rd_word : '0;
         if (aw_take) mbus_b_resp <= ~aw_in;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < DW_B; i++) begin
            if (mbus_w_strb[i]) mem[aw_idx][8*i +: 8] <= mbus_w_data[8*i +: 8];
         end
      end
   end

endmodule
